// File: rtl/parity_check_seq.sv
// parity_check_seq
// Sequential parity checker. A start request latches an N-bit word and its
// received parity bit, then folds the word into a running XOR one bit per
// clock. The result (1 = parity mismatch) is published with a one-cycle
// done_tick, and mismatches are tallied in a saturating, clearable counter.
//
// Timing with start sampled at edge 0:
//   edges 1..N  : fold data bits 0..N-1 into the accumulator
//   edge  N+1   : commit the accumulator to err, enter DONE (done_tick high)
//   edge  N+2   : return to IDLE (ready high), err_cnt updated

`timescale 1ns/1ps

module parity_check_seq #(
    parameter int N   = 8,   // data word width in bits (N >= 2)
    parameter int ODD = 0,   // 0: even parity, 1: odd parity
    parameter int CW  = 16   // error counter width in bits (CW >= 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  din,
    input  logic          pin,
    input  logic          clr_cnt,
    output logic          ready,
    output logic          done_tick,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    // Index must be able to hold N itself: it marks "all bits folded".
    localparam int IW = $clog2(N + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(N);
    localparam logic          ODD_BIT  = (ODD != 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic            acc_q,   acc_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            err_q,   err_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    // State and datapath registers; reset forces everything to its idle value.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update for the IDLE -> CHECK -> DONE sequence.
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                // start is only looked at here; CHECK/DONE ignore all inputs.
                if (start) begin
                    shreg_d = din;
                    acc_d   = pin ^ ODD_BIT;
                    idx_d   = '0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (idx_q == LAST_IDX) begin
                    // All N bits are folded in; acc now holds the verdict.
                    err_d   = acc_q;
                    state_d = DONE;
                end else begin
                    acc_d   = acc_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Error counter: count mismatches during DONE, saturate, clear wins.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == DONE) && err_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free
    // and follow reset immediately.
    always_comb begin
        ready     = (state_q == IDLE);
        done_tick = (state_q == DONE);
        err       = err_q;
        err_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_parity_check_seq.sv
// tb_parity_check_seq
// Three instances share one stimulus stream: even parity / 16-bit counter,
// odd parity / 16-bit counter, and even parity / 2-bit counter. A small
// reference model predicts err and err_cnt for each from the parity rule.

`timescale 1ns/1ps

module tb_parity_check_seq;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       pin = 1'b0;
    logic       clr_cnt = 1'b0;

    logic        ready0, done0, err0;
    logic [15:0] cnt0;
    logic        ready1, done1, err1;
    logic [15:0] cnt1;
    logic        ready2, done2, err2;
    logic [1:0]  cnt2;

    logic [2:0]  rdy_v, done_v, err_v;
    logic [15:0] cnt_v [3];

    // Reference model state per instance.
    int   odd_of  [3] = '{0, 1, 0};
    int   cnt_max [3] = '{65535, 65535, 3};
    logic exp_err [3];
    int   exp_cnt [3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    parity_check_seq #(.N(8), .ODD(0), .CW(16)) u_even (
        .clk(clk), .reset(reset), .start(start), .din(din), .pin(pin),
        .clr_cnt(clr_cnt), .ready(ready0), .done_tick(done0), .err(err0),
        .err_cnt(cnt0)
    );

    parity_check_seq #(.N(8), .ODD(1), .CW(16)) u_odd (
        .clk(clk), .reset(reset), .start(start), .din(din), .pin(pin),
        .clr_cnt(clr_cnt), .ready(ready1), .done_tick(done1), .err(err1),
        .err_cnt(cnt1)
    );

    parity_check_seq #(.N(8), .ODD(0), .CW(2)) u_cw2 (
        .clk(clk), .reset(reset), .start(start), .din(din), .pin(pin),
        .clr_cnt(clr_cnt), .ready(ready2), .done_tick(done2), .err(err2),
        .err_cnt(cnt2)
    );

    always_comb begin
        rdy_v    = {ready2, ready1, ready0};
        done_v   = {done2, done1, done0};
        err_v    = {err2, err1, err0};
        cnt_v[0] = cnt0;
        cnt_v[1] = cnt1;
        cnt_v[2] = {14'd0, cnt2};
    end

    // One full check: start at edge 0, optional junk on the inputs while busy,
    // optional clr_cnt during the DONE cycle.
    task automatic run_word(input string tag, input logic [7:0] d, input logic p,
                            input bit inject, input logic [7:0] jd, input logic jp,
                            input bit clr_at_done);
        logic nerr [3];
        for (int i = 0; i < 3; i++) nerr[i] = (^{d, p}) ^ odd_of[i][0];
        start = 1'b1; din = d; pin = p;
        // Edges 0..N: busy, no done_tick, err still holds the previous result.
        for (int k = 0; k <= N; k++) begin
            @(posedge clk); #1;
            if (inject) begin start = 1'b1; din = jd ^ 8'(k); pin = jp; end
            else start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                total_cnt++;
                if (rdy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || err_v[i] !== exp_err[i])
                    $display("FAIL %s busy[%0d] edge %0d: ready=%b done=%b err=%b, want ready=0 done=0 err=%b",
                             tag, i, k, rdy_v[i], done_v[i], err_v[i], exp_err[i]);
                else pass_cnt++;
            end
        end
        // Edge N+1: DONE cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (done_v[i] !== 1'b1 || err_v[i] !== nerr[i] || rdy_v[i] !== 1'b0 ||
                cnt_v[i] !== 16'(exp_cnt[i]))
                $display("FAIL %s done[%0d]: done=%b err=%b ready=%b cnt=%0d, want done=1 err=%b ready=0 cnt=%0d",
                         tag, i, done_v[i], err_v[i], rdy_v[i], cnt_v[i], nerr[i], exp_cnt[i]);
            else pass_cnt++;
        end
        if (clr_at_done) clr_cnt = 1'b1;
        // Edge N+2: back in IDLE, counter updated.
        @(posedge clk); #1;
        start = 1'b0; clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_err[i] = nerr[i];
            if (nerr[i] && exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
            if (clr_at_done) exp_cnt[i] = 0;
            total_cnt++;
            if (rdy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || err_v[i] !== exp_err[i] ||
                cnt_v[i] !== 16'(exp_cnt[i]))
                $display("FAIL %s idle[%0d]: ready=%b done=%b err=%b cnt=%0d, want ready=1 done=0 err=%b cnt=%0d",
                         tag, i, rdy_v[i], done_v[i], err_v[i], cnt_v[i], exp_err[i], exp_cnt[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            exp_err[i] = 1'b0; exp_cnt[i] = 0;
        end
        // Held in reset across clock edges even with start requested.
        start = 1'b1; din = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (rdy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || err_v[i] !== 1'b0 || cnt_v[i] !== 16'd0)
                $display("FAIL reset_hold[%0d]: ready=%b done=%b err=%b cnt=%0d, want 1 0 0 0",
                         i, rdy_v[i], done_v[i], err_v[i], cnt_v[i]);
            else pass_cnt++;
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (rdy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || err_v[i] !== 1'b0 || cnt_v[i] !== 16'd0)
                $display("FAIL reset_release[%0d]: ready=%b done=%b err=%b cnt=%0d, want 1 0 0 0",
                         i, rdy_v[i], done_v[i], err_v[i], cnt_v[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_vectors();
        run_word("a5_p0", 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_word("a5_p1", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_word("00_p0", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_word("01_p0", 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_word("01_p1", 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_word("80_p0", 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        run_word("ignore", 8'h03, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        // No second check may have been launched by the junk start.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                total_cnt++;
                if (rdy_v[i] !== 1'b1 || done_v[i] !== 1'b0)
                    $display("FAIL ignore_after[%0d]: ready=%b done=%b, want ready=1 done=0",
                             i, rdy_v[i], done_v[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_clr_saturate();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_cnt[i] = 0;
            total_cnt++;
            if (cnt_v[i] !== 16'd0)
                $display("FAIL clr_idle[%0d]: cnt=%0d, want 0", i, cnt_v[i]);
            else pass_cnt++;
        end
        for (int w = 0; w < 5; w++)
            run_word("sat", 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, (w == 4));
    endtask

    task automatic test_reset_mid_check();
        start = 1'b1; din = 8'h5C; pin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_err[i] = 1'b0; exp_cnt[i] = 0;
            total_cnt++;
            if (rdy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || err_v[i] !== 1'b0 || cnt_v[i] !== 16'd0)
                $display("FAIL abort[%0d]: ready=%b done=%b err=%b cnt=%0d, want 1 0 0 0",
                         i, rdy_v[i], done_v[i], err_v[i], cnt_v[i]);
            else pass_cnt++;
        end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                total_cnt++;
                if (done_v[i] !== 1'b0 || rdy_v[i] !== 1'b1)
                    $display("FAIL abort_quiet[%0d] cyc %0d: done=%b ready=%b, want done=0 ready=1",
                             i, k, done_v[i], rdy_v[i]);
                else pass_cnt++;
            end
        end
        run_word("after_abort", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int w = 0; w < 25; w++) begin
            run_word("rand", 8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                     8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_ignore_busy();
        test_clr_saturate();
        test_reset_mid_check();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
